mem_port_arbiter: RTL and testbench

- Single-clock (sys_clk domain) arbiter that lets two CPU cores share one memory load/store port pair: read port r_adrs2/r_en2 and write port w_adrs/w_en.
- Sits directly upstream of the shared memory. It replaces per-core direct wiring so core path 2 can issue loads and stores.
- Requests are latched into per-core pending slots, served round-robin one at a time, and completed with a done pulse carrying read data or an error.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_arb_slot.sv | 28 ++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-core memory port arbiter: FSM states, the
// per-core request slot record and the timeout counter width.
package mem_arb_pkg;

  localparam int TIMEOUT_CNT_W = 8;

  // The slot record is sized for the memory geometry the arbiter is built for.
  localparam int SLOT_ADDR_W = 11;
  localparam int SLOT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic                   we;
    logic [SLOT_ADDR_W-1:0] adrs;
    logic [SLOT_DATA_W-1:0] wdata;
  } req_slot_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response and memory-side load/store port bundle.
// master = arbiter view, slave = cores plus memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);

  logic [1:0]          core_req;
  logic [1:0]          core_we;
  logic [2*ADDR_W-1:0] core_adrs;
  logic [2*DATA_W-1:0] core_wdata;
  logic [1:0]          core_busy;
  logic [1:0]          core_done;
  logic [1:0]          core_err;
  logic [DATA_W-1:0]   core_rdata;

  logic                mem_r_en;
  logic [ADDR_W-1:0]   mem_r_adrs;
  logic                mem_w_en;
  logic [ADDR_W-1:0]   mem_w_adrs;
  logic [DATA_W-1:0]   mem_w_data;
  logic                mem_r_valid;
  logic                mem_w_valid;
  logic [DATA_W-1:0]   mem_r_data;

  modport master (
    input  core_req, core_we, core_adrs, core_wdata,
    input  mem_r_valid, mem_w_valid, mem_r_data,
    output core_busy, core_done, core_err, core_rdata,
    output mem_r_en, mem_r_adrs, mem_w_en, mem_w_adrs, mem_w_data
  );

  modport slave (
    output core_req, core_we, core_adrs, core_wdata,
    output mem_r_valid, mem_w_valid, mem_r_data,
    input  core_busy, core_done, core_err, core_rdata,
    input  mem_r_en, mem_r_adrs, mem_w_en, mem_w_adrs, mem_w_data
  );

endinterface

// File: rtl/mem_arb_slot.sv
// One per-core pending slot: latches a request when free, holds it until
// the arbiter clears it in the response cycle.
module mem_arb_slot
  import mem_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req,
  input  logic                   clr,
  input  logic                   we,
  input  logic [SLOT_ADDR_W-1:0] adrs,
  input  logic [SLOT_DATA_W-1:0] wdata,
  output logic                   pending,
  output req_slot_t              slot
);

  // Clear wins so a request arriving in the response cycle is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      pending <= 1'b0;
    else if (clr)     pending <= 1'b0;
    else if (req)     pending <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (req && !pending) slot <= '{we: we, adrs: adrs, wdata: wdata};
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory load/store port pair between two
// cores; one access in flight at a time, with timeout on the memory valid.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic                clk,
  input logic                resetn,
  mem_port_arbiter_if.master bus
);

  state_t                   state, state_nx;
  logic                     gnt, gnt_nx;
  logic                     last, last_nx;
  logic [TIMEOUT_CNT_W-1:0] cnt, cnt_nx;
  logic [1:0]               pending, clr;
  req_slot_t                slot_q [2];
  logic                     sel_we, hit;

  logic                     r_en_q, r_en_nx, w_en_q, w_en_nx;
  logic [ADDR_W-1:0]        r_adrs_q, r_adrs_nx, w_adrs_q, w_adrs_nx;
  logic [DATA_W-1:0]        w_data_q, w_data_nx, rdata_q, rdata_nx;
  logic [1:0]               done_q, done_nx, err_q, err_nx;

  for (genvar i = 0; i < 2; i++) begin : g_slot
    mem_arb_slot u_slot (
      .clk     (clk),
      .resetn  (resetn),
      .req     (bus.core_req[i]),
      .clr     (clr[i]),
      .we      (bus.core_we[i]),
      .adrs    (SLOT_ADDR_W'(bus.core_adrs[i*ADDR_W +: ADDR_W])),
      .wdata   (SLOT_DATA_W'(bus.core_wdata[i*DATA_W +: DATA_W])),
      .pending (pending[i]),
      .slot    (slot_q[i])
    );
  end

  assign clr    = (state == RESP) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign sel_we = slot_q[gnt].we;
  // Only the valid matching the access direction completes it.
  assign hit    = sel_we ? bus.mem_w_valid : bus.mem_r_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last     <= 1'b1;
      cnt      <= '0;
      r_en_q   <= 1'b0;
      w_en_q   <= 1'b0;
      r_adrs_q <= '0;
      w_adrs_q <= '0;
      w_data_q <= '0;
      rdata_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      last     <= last_nx;
      cnt      <= cnt_nx;
      r_en_q   <= r_en_nx;
      w_en_q   <= w_en_nx;
      r_adrs_q <= r_adrs_nx;
      w_adrs_q <= w_adrs_nx;
      w_data_q <= w_data_nx;
      rdata_q  <= rdata_nx;
      done_q   <= done_nx;
      err_q    <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (|pending) begin
          gnt_nx   = (&pending) ? ~last : pending[1];
          last_nx  = gnt_nx;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        cnt_nx   = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        if (hit || cnt == TIMEOUT_CNT_W'(TIMEOUT)) state_nx = RESP;
        else                                       cnt_nx   = cnt + TIMEOUT_CNT_W'(1);
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered, so their next values follow the state transition.
  always_comb begin
    r_en_nx   = 1'b0;
    w_en_nx   = 1'b0;
    r_adrs_nx = r_adrs_q;
    w_adrs_nx = w_adrs_q;
    w_data_nx = w_data_q;
    rdata_nx  = '0;
    done_nx   = '0;
    err_nx    = '0;
    if (state == IDLE && state_nx == ISSUE) begin
      if (slot_q[gnt_nx].we) begin
        w_en_nx   = 1'b1;
        w_adrs_nx = ADDR_W'(slot_q[gnt_nx].adrs);
        w_data_nx = DATA_W'(slot_q[gnt_nx].wdata);
      end else begin
        r_en_nx   = 1'b1;
        r_adrs_nx = ADDR_W'(slot_q[gnt_nx].adrs);
      end
    end
    if (state == WAIT && state_nx == RESP) begin
      done_nx[gnt] = 1'b1;
      err_nx[gnt]  = !hit;
      if (hit && !sel_we) rdata_nx = bus.mem_r_data;
    end
  end

  assign bus.core_busy  = pending;
  assign bus.core_done  = done_q;
  assign bus.core_err   = err_q;
  assign bus.core_rdata = rdata_q;
  assign bus.mem_r_en   = r_en_q;
  assign bus.mem_r_adrs = r_adrs_q;
  assign bus.mem_w_en   = w_en_q;
  assign bus.mem_w_adrs = w_adrs_q;
  assign bus.mem_w_data = w_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single accesses plus
// sequences for contention, fairness, ignored requests, timeout and reset.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;
  localparam int NVEC    = 8;

  typedef struct {
    int                core;
    bit                we;
    logic [ADDR_W-1:0] adrs;
    logic [DATA_W-1:0] wdata;
    bit                mute;
    int                lat;
    bit                err;
    logic [DATA_W-1:0] rdata;
  } vec_t;

  typedef struct {
    int                core;
    bit                err;
    logic [DATA_W-1:0] rdata;
    int                t;
  } done_t;

  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] adrs;
    logic [DATA_W-1:0] data;
    int                t;
  } acc_t;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mute_r = 1'b0;
  bit   mute_w = 1'b0;
  bit [DATA_W-1:0] mem [0:2047];
  done_t dq[$];
  acc_t  aq[$];
  vec_t  vecs [NVEC];

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory with one-cycle response; valids can be suppressed per direction.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.mem_r_valid <= 1'b0;
      bus.mem_w_valid <= 1'b0;
      bus.mem_r_data  <= '0;
    end else begin
      bus.mem_r_valid <= bus.mem_r_en && !mute_r;
      bus.mem_w_valid <= bus.mem_w_en && !mute_w;
      if (bus.mem_r_en) bus.mem_r_data <= mem[bus.mem_r_adrs];
      if (bus.mem_w_en) mem[bus.mem_w_adrs] <= bus.mem_w_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int mc;
  always @(negedge clk) begin
    if (bus.core_done != 2'b00) begin
      mc = bus.core_done[1] ? 1 : 0;
      dq.push_back('{core: mc, err: bus.core_err[mc], rdata: bus.core_rdata, t: cyc});
    end else begin
      chk("err_outside_resp", 32'(bus.core_err), 32'h0);
      chk("rdata_outside_resp", bus.core_rdata, 32'h0);
    end
    if (bus.mem_r_en) aq.push_back('{we: 1'b0, adrs: bus.mem_r_adrs, data: '0, t: cyc});
    if (bus.mem_w_en) aq.push_back('{we: 1'b1, adrs: bus.mem_w_adrs, data: bus.mem_w_data, t: cyc});
  end

  task automatic drive(input int c, input bit we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    bus.core_req[c]                     = 1'b1;
    bus.core_we[c]                      = we;
    bus.core_adrs[c*ADDR_W +: ADDR_W]   = a;
    bus.core_wdata[c*DATA_W +: DATA_W]  = d;
  endtask

  task automatic release_req();
    @(negedge clk);
    bus.core_req = 2'b00;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int i;
    i = 0;
    while (dq.size() < n && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk("done_count", 32'(dq.size()), 32'(n));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(bus.core_busy),  32'h0);
    chk({tag, "_done"},   32'(bus.core_done),  32'h0);
    chk({tag, "_err"},    32'(bus.core_err),   32'h0);
    chk({tag, "_rdata"},  bus.core_rdata,      32'h0);
    chk({tag, "_r_en"},   32'(bus.mem_r_en),   32'h0);
    chk({tag, "_r_adrs"}, 32'(bus.mem_r_adrs), 32'h0);
    chk({tag, "_w_en"},   32'(bus.mem_w_en),   32'h0);
    chk({tag, "_w_adrs"}, 32'(bus.mem_w_adrs), 32'h0);
    chk({tag, "_w_data"}, bus.mem_w_data,      32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n0, a0, hits, c;
    int rr [2];

    // core, we, adrs, wdata, mute, latency req->done, err, rdata
    vecs[0] = '{0, 1'b1, 11'h010, 32'hDEADBEEF, 1'b0,  4, 1'b0, 32'h0};
    vecs[1] = '{0, 1'b0, 11'h010, 32'h0,        1'b0,  4, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1, 1'b1, 11'h3FF, 32'hA5A5A5A5, 1'b0,  4, 1'b0, 32'h0};
    vecs[3] = '{1, 1'b0, 11'h3FF, 32'h0,        1'b0,  4, 1'b0, 32'hA5A5A5A5};
    vecs[4] = '{0, 1'b1, 11'h7FF, 32'hFFFFFFFF, 1'b0,  4, 1'b0, 32'h0};
    vecs[5] = '{0, 1'b0, 11'h123, 32'h0,        1'b1, 19, 1'b1, 32'h0};
    vecs[6] = '{1, 1'b1, 11'h000, 32'h13579BDF, 1'b1, 19, 1'b1, 32'h0};
    vecs[7] = '{1, 1'b0, 11'h7FF, 32'h0,        1'b0,  4, 1'b0, 32'hFFFFFFFF};

    bus.core_req   = '0;
    bus.core_we    = '0;
    bus.core_adrs  = '0;
    bus.core_wdata = '0;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      mute_r = vecs[i].mute;
      mute_w = vecs[i].mute;
      n0 = dq.size();
      a0 = aq.size();
      @(negedge clk);
      drive(vecs[i].core, vecs[i].we, vecs[i].adrs, vecs[i].wdata);
      t = cyc;
      release_req();
      wait_dones(n0 + 1, 40);
      if (dq.size() > n0) begin
        chk($sformatf("vec%0d_core", i),  32'(dq[n0].core), 32'(vecs[i].core));
        chk($sformatf("vec%0d_err", i),   32'(dq[n0].err),  32'(vecs[i].err));
        chk($sformatf("vec%0d_rdata", i), dq[n0].rdata,     vecs[i].rdata);
        chk($sformatf("vec%0d_lat", i),   32'(dq[n0].t - t), 32'(vecs[i].lat));
        chk($sformatf("vec%0d_busy_at_done", i), 32'(bus.core_busy[vecs[i].core]), 32'h1);
      end
      chk($sformatf("vec%0d_acc_count", i), 32'(aq.size() - a0), 32'h1);
      if (aq.size() > a0) begin
        chk($sformatf("vec%0d_acc_we", i),   32'(aq[a0].we),     32'(vecs[i].we));
        chk($sformatf("vec%0d_acc_adrs", i), 32'(aq[a0].adrs),   32'(vecs[i].adrs));
        chk($sformatf("vec%0d_acc_lat", i),  32'(aq[a0].t - t),  32'h2);
        if (vecs[i].we) chk($sformatf("vec%0d_acc_data", i), aq[a0].data, vecs[i].wdata);
      end
      @(negedge clk);
      #1 chk($sformatf("vec%0d_busy_after", i), 32'(bus.core_busy), 32'h0);
      @(negedge clk);
    end
    mute_r = 1'b0;
    mute_w = 1'b0;

    // Simultaneous store (core 0) and load of the same word (core 1).
    n0 = dq.size();
    a0 = aq.size();
    @(negedge clk);
    drive(0, 1'b1, 11'h020, 32'h12345678);
    drive(1, 1'b0, 11'h020, 32'h0);
    t = cyc;
    release_req();
    wait_dones(n0 + 2, 60);
    if (dq.size() >= n0 + 2) begin
      chk("sim_first_core",  32'(dq[n0].core),     32'h0);
      chk("sim_first_lat",   32'(dq[n0].t - t),    32'h4);
      chk("sim_second_core", 32'(dq[n0+1].core),   32'h1);
      chk("sim_second_data", dq[n0+1].rdata,       32'h12345678);
    end
    if (aq.size() >= a0 + 2) begin
      chk("sim_acc0_we", 32'(aq[a0].we),   32'h1);
      chk("sim_acc1_we", 32'(aq[a0+1].we), 32'h0);
      chk("sim_acc1_adrs", 32'(aq[a0+1].adrs), 32'h020);
    end
    repeat (3) @(negedge clk);

    // Both cores re-request right after each completion; grants must alternate.
    n0 = dq.size();
    rr[0] = 1;
    rr[1] = 1;
    @(negedge clk);
    drive(0, 1'b0, 11'h100, 32'h0);
    drive(1, 1'b0, 11'h101, 32'h0);
    release_req();
    for (int k = 0; k < 300 && dq.size() < n0 + 6; k++) begin
      @(negedge clk);
      #1;
      if (bus.core_done != 2'b00) begin
        c = bus.core_done[1] ? 1 : 0;
        if (rr[c] < 3) begin
          @(negedge clk);
          drive(c, 1'b0, 11'(256 + 2*rr[c] + c), 32'h0);
          rr[c]++;
          release_req();
        end
      end
    end
    chk("fair_count", 32'(dq.size() - n0), 32'h6);
    for (int k = 0; k < 6; k++) begin
      if (n0 + k < dq.size()) chk($sformatf("fair_grant%0d", k), 32'(dq[n0+k].core), 32'(k % 2));
    end
    repeat (3) @(negedge clk);

    // A second request from a busy core must leave its slot untouched.
    n0 = dq.size();
    a0 = aq.size();
    @(negedge clk);
    drive(1, 1'b0, 11'h020, 32'h0);
    @(negedge clk);
    drive(1, 1'b1, 11'h055, 32'hBAD0BAD0);
    #1 chk("ign_busy_before", 32'(bus.core_busy[1]), 32'h1);
    release_req();
    wait_dones(n0 + 1, 40);
    repeat (10) @(negedge clk);
    #1;
    chk("ign_done_count", 32'(dq.size() - n0), 32'h1);
    if (dq.size() > n0) begin
      chk("ign_core",  32'(dq[n0].core), 32'h1);
      chk("ign_rdata", dq[n0].rdata,     32'h12345678);
    end
    hits = 0;
    for (int k = a0; k < aq.size(); k++) if (aq[k].adrs == 11'h055) hits++;
    chk("ign_no_055", 32'(hits), 32'h0);
    chk("ign_acc_count", 32'(aq.size() - a0), 32'h1);
    chk("ign_busy_after", 32'(bus.core_busy), 32'h0);

    // Timed-out load followed by a store already pending from the other core.
    mute_r = 1'b1;
    n0 = dq.size();
    a0 = aq.size();
    @(negedge clk);
    drive(0, 1'b0, 11'h200, 32'h0);
    t = cyc;
    release_req();
    repeat (2) @(negedge clk);
    drive(1, 1'b1, 11'h201, 32'h0BADF00D);
    release_req();
    wait_dones(n0 + 2, 80);
    mute_r = 1'b0;
    if (dq.size() >= n0 + 2) begin
      chk("to_core",     32'(dq[n0].core),    32'h0);
      chk("to_err",      32'(dq[n0].err),     32'h1);
      chk("to_rdata",    dq[n0].rdata,        32'h0);
      chk("to_lat",      32'(dq[n0].t - t),   32'(TIMEOUT + 4));
      chk("to_next_core", 32'(dq[n0+1].core), 32'h1);
      chk("to_next_err",  32'(dq[n0+1].err),  32'h0);
      chk("to_next_lat",  32'(dq[n0+1].t - t), 32'(TIMEOUT + 8));
    end
    if (aq.size() >= a0 + 2) chk("to_next_adrs", 32'(aq[a0+1].adrs), 32'h201);
    repeat (3) @(negedge clk);

    // Reset while waiting on memory: outputs clear, no completion appears.
    mute_r = 1'b1;
    @(negedge clk);
    drive(0, 1'b0, 11'h300, 32'h0);
    release_req();
    repeat (4) @(negedge clk);
    n0 = dq.size();
    #2 resetn = 1'b0;
    #1 chk_all_zero("rst_wait");
    repeat (2) @(negedge clk);
    #1 chk("rst_no_done", 32'(dq.size() - n0), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    mute_r = 1'b0;
    @(negedge clk);
    drive(0, 1'b0, 11'h010, 32'h0);
    drive(1, 1'b0, 11'h3FF, 32'h0);
    t = cyc;
    release_req();
    wait_dones(n0 + 2, 60);
    if (dq.size() >= n0 + 2) begin
      chk("post_rst_core0",  32'(dq[n0].core),   32'h0);
      chk("post_rst_rdata0", dq[n0].rdata,       32'hDEADBEEF);
      chk("post_rst_lat",    32'(dq[n0].t - t),  32'h4);
      chk("post_rst_core1",  32'(dq[n0+1].core), 32'h1);
      chk("post_rst_rdata1", dq[n0+1].rdata,     32'hA5A5A5A5);
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
